// File: rtl/cache_addr_encoder.sv
// Line-burst address generator: turns a {tag, index} line identity into 2**OFFSET_WIDTH beat addresses.
// Optional macro CACHE_ENC_CRITICAL_WORD_FIRST_EN starts each burst at req_offset instead of 0.
module cache_addr_encoder #(
   parameter int ADDR_WIDTH   = 32,
   parameter int TAG_WIDTH    = 24,
   parameter int INDEX_WIDTH  = 6,
   parameter int OFFSET_WIDTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [TAG_WIDTH-1:0]    req_tag,
   input  logic [INDEX_WIDTH-1:0]  req_index,
   input  logic [OFFSET_WIDTH-1:0] req_offset,
   output logic                    mem_addr_valid,
   input  logic                    mem_addr_ready,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_addr_last,
   output logic                    busy,
   output logic                    done
);

   generate
      if (TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH != ADDR_WIDTH) begin : g_width_chk
         $error("cache_addr_encoder: tag+index+offset widths must equal ADDR_WIDTH");
      end
   endgenerate

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t                  state, state_nxt;
   logic [TAG_WIDTH-1:0]    tag_q;
   logic [INDEX_WIDTH-1:0]  index_q;
   logic [OFFSET_WIDTH-1:0] cur_off;
   logic [OFFSET_WIDTH-1:0] beat_cnt;
   logic [OFFSET_WIDTH-1:0] start_off;
   logic                    done_q;
   logic                    accept;
   logic                    beat_fire;
   logic                    final_beat;

`ifdef CACHE_ENC_CRITICAL_WORD_FIRST_EN
   assign start_off = req_offset;
`else
   // Sequential order only; the offset port exists but is not consumed.
   logic unused_offset;
   assign unused_offset = ^req_offset;
   assign start_off     = '0;
`endif

   // The beat counter, not cur_off, decides the end of the line so wrapped bursts still end after a full line.
   assign final_beat = &beat_cnt;

   always_comb begin
      state_nxt      = state;
      req_ready      = 1'b0;
      mem_addr_valid = 1'b0;
      busy           = 1'b0;
      accept         = 1'b0;
      beat_fire      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = BURST;
            end
         end
         BURST: begin
            busy           = 1'b1;
            mem_addr_valid = 1'b1;
            if (mem_addr_ready) begin
               beat_fire = 1'b1;
               if (final_beat) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_addr      = {tag_q, index_q, cur_off};
   assign mem_addr_last = (state == BURST) && final_beat;
   assign done          = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tag_q    <= '0;
         index_q  <= '0;
         cur_off  <= '0;
         beat_cnt <= '0;
         done_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= beat_fire && final_beat;
         if (accept) begin
            tag_q    <= req_tag;
            index_q  <= req_index;
            cur_off  <= start_off;
            beat_cnt <= '0;
         end else if (beat_fire) begin
            cur_off  <= cur_off + 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/cache_addr_encoder.md
Name: cache_addr_encoder

Overview:
Inverse of the cache address decoder. It takes a {tag, index} line identity plus a starting block offset and regenerates the full 32-bit word addresses for a whole-line burst toward memory. The cache controller uses it for refill and writeback bursts. It sits between the controller (request side) and the memory address channel, using a valid/ready handshake on both sides.

Parameters:
ADDR_WIDTH, 32, memory address width
TAG_WIDTH, 24, tag field width
INDEX_WIDTH, 6, index field width
OFFSET_WIDTH, 2, block-offset field width; words per line = 2**OFFSET_WIDTH
Constraint: TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH == ADDR_WIDTH (elaboration-time check).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  controller presents a line request
req_ready  output  1  encoder can accept a request
req_tag  input  TAG_WIDTH  line tag
req_index  input  INDEX_WIDTH  line index
req_offset  input  OFFSET_WIDTH  starting word (used only with optional feature)
mem_addr_valid  output  1  mem_addr holds a valid beat address
mem_addr_ready  input  1  memory accepts current beat
mem_addr  output  ADDR_WIDTH  {tag, index, beat_offset}
mem_addr_last  output  1  current beat is final beat of the line
busy  output  1  burst in progress
done  output  1  one-cycle pulse after last beat accepted

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, mem_addr_valid=0, mem_addr=0, mem_addr_last=0, busy=0, done=0, beat counter=0.
- FSM states: IDLE, BURST.
- IDLE:
  - req_ready=1, mem_addr_valid=0.
  - On req_valid, register tag, index and start offset (0 without the optional feature), clear beat counter, and go to BURST.
  - The first beat is valid the cycle after acceptance (1-cycle latency).
- BURST:
  - req_ready=0, busy=1, mem_addr_valid=1.
  - mem_addr = {tag_q, index_q, cur_off}.
  - mem_addr_last=1 when beat counter == 2**OFFSET_WIDTH-1.
- Beat advance: on mem_addr_valid && mem_addr_ready, cur_off increments modulo 2**OFFSET_WIDTH (wraps 3->0) and the beat counter increments.
- Address stability: while valid && !ready, mem_addr and mem_addr_last hold unchanged. Valid never drops mid-burst.
- Burst end:
  - When the last beat is handshaken, the next cycle has state=IDLE, busy=0, done=1 (one cycle only), req_ready=1.
  - A new request may be accepted in that same cycle, so back-to-back bursts are separated by one address-idle cycle.
- Exactly 2**OFFSET_WIDTH beats per request. No early termination except reset.
- req_* inputs are ignored outside IDLE; changes to them mid-burst have no effect.
- Reset mid-burst: the next cycle is IDLE with all outputs at reset values. No done pulse; the partial burst is abandoned.
- rst has priority over every handshake in the same cycle.

Optional Feature:
Macro CACHE_ENC_CRITICAL_WORD_FIRST_EN.
- Defined: the burst starts at the registered req_offset and wraps modulo line size (critical-word-first refill). mem_addr_last still asserts on the 4th beat, whatever the start offset.
- Undefined: req_offset is ignored and every burst starts at offset 0 (sequential order). The port still exists, left unconnected internally.

Test Plan:
- Reset then idle -> req_ready=1, mem_addr_valid=0, busy=0, done=0 for 5 cycles.
- Request tag=24'hDEADBE, index=6'h3B, mem_addr_ready held 1 -> mem_addr sequence 0xDEADBEEC, 0xDEADBEED, 0xDEADBEEE, 0xDEADBEEF on 4 consecutive cycles; last only on 0xDEADBEEF; done pulses 1 cycle later.
- Same request with mem_addr_ready low for 3 cycles on beat 2 -> mem_addr holds 0xDEADBEED stable and valid, then resumes; 4 beats total.
- With CACHE_ENC_CRITICAL_WORD_FIRST_EN and req_offset=2'b11 -> 0xDEADBEEF, 0xDEADBEEC, 0xDEADBEED, 0xDEADBEEE; last on 0xDEADBEEE. Without the macro, same stimulus -> 0xDEADBEEC first.
- rst asserted after beat 2 accepted -> next cycle IDLE, valid=0, no done pulse. A new request tag=24'h000001, index=6'h00 then produces 0x00000100..0x00000103.
- req_valid held high across a burst end -> second request accepted in the done cycle; its first beat appears one cycle later.
